// File: rtl/edram_pkg.sv
// Shared defaults and state encoding for the eDRAM bank model.
package edram_pkg;

    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 4;
    localparam int DEF_MEM_LAT    = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bank_state_t;

endpackage

// File: rtl/edram_array.sv
// Storage for the eDRAM bank: data words, per-entry read counters and,
// when EDRAM_BANK_PARITY_EN is defined, one even-parity bit per word.
// A read commit decrements the entry's counter in the same edge it
// returns the word; an exhausted entry returns zero and flags err.
module edram_array
    import edram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [CNT_WIDTH-1:0]  wcount,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  consumed,
    output logic [ADDR_WIDTH-1:0] consumed_addr,
    output logic                  err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_mem  [DEPTH];
    logic                  cnt_zero;
    logic                  par_bad;

    assign cnt_zero = (cnt_mem[addr] == '0);

`ifdef EDRAM_BANK_PARITY_EN
    logic par_mem [DEPTH];

    // Parity bit written alongside each data word (not reset, like the data).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem[addr] <= ^wdata;
        end
    end

    assign par_bad = ((^data_mem[addr]) != par_mem[addr]);
`else
    assign par_bad = 1'b0;
`endif

    // Data words are never reset; contents survive nrst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[addr] <= wdata;
        end
    end

    // Read counters: load on write, saturating decrement on read (never below 0).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_mem[i] <= '0;
            end
        end else if (wr_en) begin
            cnt_mem[addr] <= wcount;
        end else if (rd_en && !cnt_zero) begin
            cnt_mem[addr] <= cnt_mem[addr] - CNT_ONE;
        end
    end

    // Registered read response and status pulses for a read commit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            consumed      <= 1'b0;
            consumed_addr <= '0;
            err           <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            consumed <= 1'b0;
            err      <= 1'b0;
            if (rd_en) begin
                if (cnt_zero) begin
                    rd_data <= '0;
                    err     <= 1'b1;
                end else begin
                    rd_data <= data_mem[addr];
                    err     <= par_bad;
                    if (cnt_mem[addr] == CNT_ONE) begin
                        consumed      <= 1'b1;
                        consumed_addr <= addr;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/edram_bank.sv
// eDRAM bank controller: accepts one read or write, waits MEM_LAT edges,
// commits it to edram_array, then waits in DONE until both requests drop
// so that a held request is executed only once.
// Optional feature: define EDRAM_BANK_PARITY_EN to add per-word parity
// checking on reads.
module edram_bank
    import edram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int MEM_LAT    = DEF_MEM_LAT
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  ram_ren,
    input  logic                  ram_wen,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    input  logic [CNT_WIDTH-1:0]  ram_count,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  consumed,
    output logic [ADDR_WIDTH-1:0] consumed_addr,
    output logic                  busy,
    output logic                  err
);

    // lat_cnt counts 0..MEM_LAT-1, so four bits cover the full 1..15 range.
    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    bank_state_t           state;
    logic [3:0]            lat_cnt;
    logic                  op_wr;
    logic [ADDR_WIDTH-1:0] op_addr_p0;
    logic [DATA_WIDTH-1:0] op_data_p0;
    logic [CNT_WIDTH-1:0]  op_count_p0;
    logic                  err_req;
    logic                  arr_err;
    logic                  commit;
    logic                  start;

    assign start  = (state == IDLE) && (ram_ren || ram_wen);
    assign commit = (state == ACCESS) && (lat_cnt == LAT_LAST);

    // Control FSM with registered busy and illegal-request error pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            lat_cnt <= '0;
            op_wr   <= 1'b0;
            busy    <= 1'b0;
            err_req <= 1'b0;
        end else begin
            err_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (ram_ren || ram_wen) begin
                        lat_cnt <= '0;
                        busy    <= 1'b1;
                        if (ram_ren && ram_wen) begin
                            err_req <= 1'b1;
                            state   <= DONE;
                        end else begin
                            op_wr <= ram_wen;
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    lat_cnt <= lat_cnt + 4'd1;
                    if (lat_cnt == LAT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!ram_ren && !ram_wen) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (start) begin
            op_addr_p0  <= ram_addr;
            op_data_p0  <= ram_data;
            op_count_p0 <= ram_count;
        end
    end

    edram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_array (
        .clk           (clk),
        .nrst          (nrst),
        .wr_en         (commit && op_wr),
        .rd_en         (commit && !op_wr),
        .addr          (op_addr_p0),
        .wdata         (op_data_p0),
        .wcount        (op_count_p0),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .consumed      (consumed),
        .consumed_addr (consumed_addr),
        .err           (arr_err)
    );

    assign err = err_req || arr_err;

endmodule

// File: tb/tb_edram_bank.sv
// Bench for edram_bank: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the bank contents.
module tb_edram_bank;
    import edram_pkg::*;

    localparam int AW  = 6;
    localparam int DW  = 16;
    localparam int CW  = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          nrst;
    logic          ram_ren;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [CW-1:0] ram_count;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          consumed;
    logic [AW-1:0] consumed_addr;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Model of the bank: stored words, remaining reads, last returned word.
    logic [DW-1:0] m_data [2**AW];
    int            m_cnt  [2**AW];
    logic [DW-1:0] m_rd;

    edram_bank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .MEM_LAT    (LAT)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .ram_ren       (ram_ren),
        .ram_wen       (ram_wen),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .ram_count     (ram_count),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .consumed      (consumed),
        .consumed_addr (consumed_addr),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Assert reset, verify every output is cleared, release on a posedge+1 slot.
    task automatic do_reset();
        ram_ren = 1'b0;
        ram_wen = 1'b0;
        nrst    = 1'b0;
        #1;
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_consumed", 32'(consumed), 32'd0);
        chk("rst_consumed_addr", 32'(consumed_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_rd = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    // One request held for 'hold' edges, then dropped; observed pulses are
    // compared with what the model says this request must produce.
    task automatic op(input bit ren, input bit wen, input int a, input int d,
                      input int c, input int hold, input bit par_bad);
        bit            illegal;
        bit            exp_rv;
        bit            exp_cons;
        bit            exp_err;
        logic [DW-1:0] exp_rd;
        int            exp_k;
        int            rv_n;
        int            cons_n;
        int            err_n;
        int            rv_k;
        int            err_k;
        logic [DW-1:0] rd_seen;
        logic [AW-1:0] cons_a;
        logic          busy0;
        logic          busy_hold;
        bit            finished;

        illegal  = ren && wen;
        exp_rv   = 1'b0;
        exp_cons = 1'b0;
        exp_err  = 1'b0;
        exp_rd   = m_rd;
        exp_k    = illegal ? 0 : LAT;
        if (illegal) begin
            exp_err = 1'b1;
        end else if (wen) begin
            m_data[a] = DW'(d);
            m_cnt[a]  = c;
        end else begin
            exp_rv = 1'b1;
            if (m_cnt[a] > 0) begin
                exp_rd   = m_data[a];
                m_cnt[a] = m_cnt[a] - 1;
                exp_cons = (m_cnt[a] == 0);
                exp_err  = par_bad;
            end else begin
                exp_rd  = '0;
                exp_err = 1'b1;
            end
            m_rd = exp_rd;
        end

        ram_ren   = ren;
        ram_wen   = wen;
        ram_addr  = AW'(a);
        ram_data  = DW'(d);
        ram_count = CW'(c);
        rv_n = 0; cons_n = 0; err_n = 0; rv_k = -1; err_k = -1;
        rd_seen = '0; cons_a = '0; busy0 = 1'b0; busy_hold = 1'b0;
        finished = 1'b0;

        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (rd_valid) begin rv_n++; rv_k = k; rd_seen = rd_data; end
            if (consumed) begin cons_n++; cons_a = consumed_addr; end
            if (err) begin err_n++; err_k = k; end
            if (k == 0) busy0 = busy;
            if (k == hold - 1) busy_hold = busy;
            if (k >= hold && !busy) begin
                finished = 1'b1;
                break;
            end
            if (k < hold - 1) begin
                ram_addr  = AW'($urandom);
                ram_data  = DW'($urandom);
                ram_count = CW'($urandom);
            end
            if (k == hold - 1) begin
                ram_ren = 1'b0;
                ram_wen = 1'b0;
            end
        end

        chk("busy_start", 32'(busy0), 32'd1);
        chk("busy_held", 32'(busy_hold), 32'd1);
        chk("return_idle", 32'(finished), 32'd1);
        chk("rd_valid_count", 32'(rv_n), 32'(exp_rv));
        chk("consumed_count", 32'(cons_n), 32'(exp_cons));
        chk("err_count", 32'(err_n), 32'(exp_err));
        if (exp_rv) begin
            chk("rd_valid_edge", 32'(rv_k), 32'(exp_k));
            chk("rd_data", 32'(rd_seen), 32'(exp_rd));
        end
        if (exp_cons) chk("consumed_addr", 32'(cons_a), 32'(a));
        if (exp_err) chk("err_edge", 32'(err_k), 32'(exp_k));
        chk("rd_data_hold", 32'(rd_data), 32'(m_rd));
    endtask

    initial begin
        int r;
        nrst      = 1'b1;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_data  = '0;
        ram_count = '0;
        foreach (m_data[i]) m_data[i] = '0;
        #1;
        do_reset();

        // Write then read path with exhaustion of a count-2 entry.
        op(0, 1, 5, 16'hBEEF, 2, LAT + 1, 0);
        op(1, 0, 5, 0, 0, LAT + 1, 0);
        op(1, 0, 5, 0, 0, LAT + 1, 0);
        op(1, 0, 5, 0, 0, LAT + 1, 0);

        // Illegal simultaneous request must leave entry 3 untouched.
        op(0, 1, 3, 16'h1234, 1, LAT + 1, 0);
        op(1, 1, 3, 16'hDEAD, 7, LAT + 2, 0);
        op(1, 0, 3, 0, 0, LAT + 1, 0);

        // Read held for six cycles executes once.
        op(0, 1, 11, 16'hA5A5, 3, LAT + 1, 0);
        op(1, 0, 11, 0, 0, 6, 0);
        op(1, 0, 11, 0, 0, LAT + 1, 0);
        op(1, 0, 11, 0, 0, LAT + 1, 0);
        op(1, 0, 11, 0, 0, LAT + 1, 0);

        // Zero-count write and maximum-count write.
        op(0, 1, 20, 16'h0F0F, 0, LAT + 1, 0);
        op(1, 0, 20, 0, 0, LAT + 1, 0);
        op(0, 1, 21, 16'h7777, 15, LAT + 1, 0);
        for (int i = 0; i < 16; i++) op(1, 0, 21, 0, 0, LAT + 1, 0);

        // Reset during ACCESS of a write aborts it.
        ram_wen   = 1'b1;
        ram_addr  = AW'(9);
        ram_data  = 16'h9999;
        ram_count = CW'(1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("state_access", 32'(dut.state), 32'(ACCESS));
        do_reset();
        op(1, 0, 9, 0, 0, LAT + 1, 0);

`ifdef EDRAM_BANK_PARITY_EN
        // Corrupted stored word is still returned, with err alongside.
        op(0, 1, 7, 16'h00F0, 2, LAT + 1, 0);
        dut.u_array.data_mem[7][0] = ~dut.u_array.data_mem[7][0];
        m_data[7][0] = ~m_data[7][0];
        op(1, 0, 7, 0, 0, LAT + 1, 1);
`endif

        // Random traffic over a small address window.
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(99, 0);
            if (r < 45)
                op(0, 1, $urandom_range(7, 0), $urandom_range(65535, 0),
                   $urandom_range(3, 0), $urandom_range(LAT + 4, LAT + 1), 0);
            else if (r < 90)
                op(1, 0, $urandom_range(7, 0), 0, 0, $urandom_range(LAT + 4, LAT + 1), 0);
            else
                op(1, 1, $urandom_range(7, 0), $urandom_range(65535, 0),
                   $urandom_range(3, 0), $urandom_range(LAT + 4, LAT + 1), 0);
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
